// File: rtl/uart_rx_engine_pkg.sv
// Shared types for the UART receive engine: parity mode, receiver state, IRQ flag layout.
package uart_rx_engine_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } Parity_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_SHIFT  = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } RXState_t;

   typedef struct packed {
      logic overrun_error;
      logic framing_error;
      logic parity_error;
      logic fifo_full;
      logic fifo_half_full;
      logic data_ready;
   } RXIrqFlags_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_engine_fifo.sv
// Show-ahead RX FIFO with registered head word, occupancy and status bits.
module uart_rx_engine_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     half_full,
   output logic                     full,
   output logic                     rts_n,
   output logic                     overrun_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic [LW-1:0]    level_next;
   logic [WIDTH-1:0] head_next;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
   always_comb begin
      do_pop     = pop && valid && !flush;
      do_push    = push && !flush && (!full || do_pop);
      overrun_c  = push && !flush && full && !do_pop;
      rd_next    = flush ? '0 : rd_ptr + AW'(do_pop);
      level_next = flush ? '0 : level + LW'(do_push) - LW'(do_pop);
      head_next  = head;
      if (level_next != '0) begin
         head_next = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         head      <= '0;
         valid     <= 1'b0;
         half_full <= 1'b0;
         full      <= 1'b0;
         rts_n     <= 1'b0;
      end else begin
         wr_ptr    <= flush ? '0 : wr_ptr + AW'(do_push);
         rd_ptr    <= rd_next;
         level     <= level_next;
         head      <= head_next;
         valid     <= (level_next != '0);
         half_full <= (level_next >= LW'(DEPTH / 2));
         full      <= (level_next == LW'(DEPTH));
         rts_n     <= (level_next >= LW'(DEPTH - 2));
      end
   end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: prescaler, oversampled frame FSM, sticky error flags and RX FIFO.
// Optional idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_engine
   import uart_rx_engine_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DIV_WIDTH-1:0]          divider_i,
   input  logic [1:0]                    parity_i,
   input  logic                          two_stop_i,
   input  logic                          flush_i,
   input  logic                          err_clear_i,
   input  logic                          rx_i,
   output logic [DATA_BITS-1:0]          rx_data_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic [5:0]                    irq_flags_o,
   output logic                          rts_n_o,
   output logic                          timeout_o
);

   localparam int unsigned SW  = $clog2(OVERSAMPLE);
   localparam int unsigned MID = OVERSAMPLE / 2;
   localparam int unsigned BW  = $clog2(DATA_BITS + 1);

   logic [1:0]           sync;
   logic                 rx_s;
   logic [DIV_WIDTH-1:0] pre_cnt;
   logic [DIV_WIDTH-1:0] div_q;
   logic                 tick_c;
   logic                 start_c;
   RXState_t             state;
   logic                 armed;
   logic [SW-1:0]        s_cnt;
   logic [1:0]           smp;
   logic                 bit_val_c;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   Parity_t              parity_q;
   logic                 two_stop_q;
   logic                 perr_f;
   logic                 ferr_f;
   logic                 push_q;
   logic                 push_perr_q;
   logic                 push_ferr_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 ovr_q;
   logic                 pop_c;
   logic                 overrun_c;
   logic                 fifo_half;
   logic                 fifo_full;
   RXIrqFlags_t          irq;

   assign rx_s      = sync[1];
   assign tick_c    = (pre_cnt == '0);
   assign start_c   = (state == RX_IDLE) && armed && !rx_s;
   assign bit_val_c = majority3(smp[0], smp[1], rx_s);
   assign pop_c     = rx_valid_o && rx_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], rx_i};
      end
   end

   // Prescaler restarts on a start edge so sample points align with the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (start_c) begin
         pre_cnt <= divider_i;
      end else if (tick_c) begin
         pre_cnt <= (state == RX_IDLE) ? divider_i : div_q;
      end else begin
         pre_cnt <= pre_cnt - DIV_WIDTH'(1);
      end
   end

   // Frame FSM; each bit is decided one tick after mid, once all three votes are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RX_IDLE;
         armed       <= 1'b0;
         s_cnt       <= '0;
         smp         <= 2'b11;
         bit_cnt     <= '0;
         shreg       <= '0;
         parity_q    <= PAR_NONE;
         two_stop_q  <= 1'b0;
         div_q       <= '0;
         perr_f      <= 1'b0;
         ferr_f      <= 1'b0;
         push_q      <= 1'b0;
         push_perr_q <= 1'b0;
         push_ferr_q <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (state == RX_IDLE) begin
            if (rx_s) begin
               armed <= 1'b1;
            end else if (armed) begin
               state      <= RX_START;
               armed      <= 1'b0;
               s_cnt      <= '0;
               bit_cnt    <= '0;
               perr_f     <= 1'b0;
               ferr_f     <= 1'b0;
               parity_q   <= Parity_t'(parity_i);
               two_stop_q <= two_stop_i;
               div_q      <= divider_i;
            end
         end else if (tick_c) begin
            s_cnt <= (s_cnt == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt + SW'(1);
            if (s_cnt == SW'(MID - 1)) smp[0] <= rx_s;
            if (s_cnt == SW'(MID))     smp[1] <= rx_s;
            if (s_cnt == SW'(MID + 1)) begin
               case (state)
                  RX_START: state <= bit_val_c ? RX_IDLE : RX_SHIFT;
                  RX_SHIFT: begin
                     shreg <= {bit_val_c, shreg[DATA_BITS-1:1]};
                     if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= (parity_q != PAR_NONE) ? RX_PARITY : RX_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end
                  RX_PARITY: begin
                     perr_f <= ((^shreg) ^ bit_val_c) != (parity_q == PAR_ODD);
                     state  <= RX_STOP;
                  end
                  RX_STOP: begin
                     if (two_stop_q && (bit_cnt == '0)) begin
                        bit_cnt <= BW'(1);
                        ferr_f  <= ferr_f | !bit_val_c;
                     end else begin
                        push_q      <= 1'b1;
                        push_perr_q <= perr_f;
                        push_ferr_q <= ferr_f | !bit_val_c;
                        state       <= RX_IDLE;
                     end
                  end
                  default: state <= RX_IDLE;
               endcase
            end
         end
      end
   end

   // Sticky errors: a new error in the clear cycle takes priority over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         perr_q <= (perr_q & ~err_clear_i) | (push_q & push_perr_q);
         ferr_q <= (ferr_q & ~err_clear_i) | (push_q & push_ferr_q);
         ovr_q  <= (ovr_q & ~err_clear_i) | overrun_c;
      end
   end

   uart_rx_engine_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_q),
      .push_data (shreg),
      .pop       (rx_ready_i),
      .flush     (flush_i),
      .head      (rx_data_o),
      .valid     (rx_valid_o),
      .level     (level_o),
      .half_full (fifo_half),
      .full      (fifo_full),
      .rts_n     (rts_n_o),
      .overrun_c (overrun_c)
   );

   always_comb begin
      irq                = '0;
      irq.overrun_error  = ovr_q;
      irq.framing_error  = ferr_q;
      irq.parity_error   = perr_q;
      irq.fifo_full      = fifo_full;
      irq.fifo_half_full = fifo_half;
      irq.data_ready     = rx_valid_o;
   end
   assign irq_flags_o = irq;

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TO_BITS = 4 * (DATA_BITS + 2);
   localparam int unsigned TW      = $clog2(TO_BITS + 1);

   logic          rx_d;
   logic [SW-1:0] to_sub;
   logic [TW-1:0] to_cnt;
   logic          to_rst_c;

   assign to_rst_c = (rx_s != rx_d) || pop_c || flush_i || err_clear_i;

   // Idle counter in bit periods, saturating at the timeout threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_d      <= 1'b1;
         to_sub    <= '0;
         to_cnt    <= '0;
         timeout_o <= 1'b0;
      end else begin
         rx_d <= rx_s;
         if (to_rst_c) begin
            to_sub <= '0;
            to_cnt <= '0;
         end else if (tick_c && (to_cnt != TW'(TO_BITS))) begin
            if (to_sub == SW'(OVERSAMPLE - 1)) begin
               to_sub <= '0;
               to_cnt <= to_cnt + TW'(1);
            end else begin
               to_sub <= to_sub + SW'(1);
            end
         end
         if (pop_c || flush_i || err_clear_i) begin
            timeout_o <= 1'b0;
         end else if ((to_cnt == TW'(TO_BITS)) && rx_valid_o) begin
            timeout_o <= 1'b1;
         end
      end
   end
`else
   logic unused_pop;
   assign unused_pop = pop_c;
   assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: serial frames vs. a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_engine;
   import uart_rx_engine_pkg::*;

   localparam int unsigned DB    = 8;
   localparam int unsigned OS    = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] divider_i = '0;
   logic [1:0]    parity_i = 2'd0;
   logic          two_stop_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          err_clear_i = 1'b0;
   logic          rx_i = 1'b1;
   logic [DB-1:0] rx_data_o;
   logic          rx_valid_o;
   logic          rx_ready_i = 1'b0;
   logic [4:0]    level_o;
   logic [5:0]    irq_flags_o;
   logic          rts_n_o;
   logic          timeout_o;

   always #5 clk = ~clk;

   uart_rx_engine #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .divider_i(divider_i), .parity_i(parity_i),
      .two_stop_i(two_stop_i), .flush_i(flush_i), .err_clear_i(err_clear_i),
      .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .level_o(level_o), .irq_flags_o(irq_flags_o),
      .rts_n_o(rts_n_o), .timeout_o(timeout_o)
   );

   int checks = 0;
   int errors = 0;
   int div = 0;

   // Reference model: expected FIFO contents and sticky error state.
   logic [DB-1:0] mq[$];
   bit m_pe, m_fe, m_ovr;

   function automatic logic [5:0] exp_irq();
      int n;
      n = mq.size();
      return {m_ovr, m_fe, m_pe, (n == DEPTH), (n >= DEPTH / 2), (n > 0)};
   endfunction

   task automatic hold(input logic v, input int bits);
      rx_i = v;
      repeat (bits * OS * (div + 1)) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] par, input bit two,
                             input bit bad_par, input bit bad_s1, input bit bad_s2);
      logic p;
      divider_i  = DW'(div);
      parity_i   = par;
      two_stop_i = two;
      hold(1'b0, 1);
      for (int i = 0; i < DB; i++) hold(d[i], 1);
      if (par != PAR_NONE) begin
         p = ^d;
         if (par == PAR_ODD) p = ~p;
         hold(p ^ bad_par, 1);
      end
      hold(~bad_s1, 1);
      if (two) hold(~bad_s2, 1);
      hold(1'b1, 2);
      if ((par != PAR_NONE) && bad_par) m_pe = 1'b1;
      if (bad_s1 || (two && bad_s2)) m_fe = 1'b1;
      if (mq.size() == DEPTH) m_ovr = 1'b1;
      else mq.push_back(d);
   endtask

   task automatic do_pop();
      rx_ready_i = 1'b1;
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic do_clear();
      err_clear_i = 1'b1;
      @(posedge clk); #1;
      err_clear_i = 1'b0;
      m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_data_o, rx_valid_o, level_o, irq_flags_o, rts_n_o, timeout_o} !== '0) begin
         errors++;
         $display("FAIL reset_asserted: data=%h valid=%b level=%0d irq=%b rts_n=%b to=%b, required all 0",
                  rx_data_o, rx_valid_o, level_o, irq_flags_o, rts_n_o, timeout_o);
      end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_valid_o, level_o, irq_flags_o, rts_n_o, timeout_o} !== '0) begin
         errors++;
         $display("FAIL reset_released: valid=%b level=%0d irq=%b rts_n=%b, required all 0",
                  rx_valid_o, level_o, irq_flags_o, rts_n_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      div = 0;
      send_frame(8'hA5, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (rx_data_o !== 8'hA5 || rx_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_data: data=%h valid=%b, required A5 1", rx_data_o, rx_valid_o);
      end
      checks++;
      if (irq_flags_o !== exp_irq()) begin
         errors++;
         $display("FAIL basic_irq: irq=%b required %b", irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      do_pop();
      @(negedge clk);
      checks++;
      if (rx_valid_o !== 1'b0 || level_o !== 5'd0) begin
         errors++;
         $display("FAIL basic_pop: valid=%b level=%0d, required 0 0", rx_valid_o, level_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_parity();
      div = 0;
      send_frame(8'h07, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (50) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rx_data_o !== 8'h07 || irq_flags_o !== exp_irq() || irq_flags_o[3] !== 1'b1) begin
         errors++;
         $display("FAIL parity_set: data=%h irq=%b, required 07 %b", rx_data_o, irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      do_pop();
      @(negedge clk);
      checks++;
      if (irq_flags_o !== exp_irq()) begin
         errors++;
         $display("FAIL parity_sticky: irq=%b required %b", irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      do_clear();
      @(negedge clk);
      checks++;
      if (irq_flags_o !== 6'b0) begin
         errors++;
         $display("FAIL parity_clear: irq=%b required 000000", irq_flags_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_false_start();
      rx_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (60) @(posedge clk);
      @(negedge clk);
      checks++;
      if (level_o !== 5'd0 || irq_flags_o !== 6'b0) begin
         errors++;
         $display("FAIL false_start: level=%0d irq=%b, required 0 000000", level_o, irq_flags_o);
      end
      @(posedge clk); #1;
      send_frame(8'h5A, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (rx_data_o !== 8'h5A || level_o !== 5'd1) begin
         errors++;
         $display("FAIL after_false_start: data=%h level=%0d, required 5a 1", rx_data_o, level_o);
      end
      @(posedge clk); #1;
      do_pop();
   endtask

   task automatic test_random();
      logic [DB-1:0] d;
      logic [1:0] par;
      bit two, bp, bs1, bs2;
      for (int it = 0; it < 16; it++) begin
         d   = DB'($urandom);
         par = 2'($urandom_range(0, 2));
         two = 1'($urandom_range(0, 1));
         bp  = ($urandom_range(0, 3) == 0);
         bs1 = ($urandom_range(0, 4) == 0);
         bs2 = ($urandom_range(0, 4) == 0);
         div = $urandom_range(0, 3);
         send_frame(d, par, two, bp, bs1, bs2);
         @(negedge clk);
         checks++;
         if (level_o !== 5'(mq.size()) || (mq.size() > 0 && rx_data_o !== mq[0])) begin
            errors++;
            $display("FAIL random_data[%0d]: data=%h level=%0d, required %h %0d",
                     it, rx_data_o, level_o, d, mq.size());
         end
         checks++;
         if (irq_flags_o !== exp_irq()) begin
            errors++;
            $display("FAIL random_irq[%0d]: irq=%b required %b (par=%0d two=%0d)",
                     it, irq_flags_o, exp_irq(), par, two);
         end
         @(posedge clk); #1;
         do_pop();
         do_clear();
      end
      div = 0;
   endtask

   task automatic test_overrun();
      div = 0;
      for (int i = 0; i < 17; i++) begin
         send_frame(DB'(i), PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         checks++;
         if (rts_n_o !== (mq.size() >= DEPTH - 2) || level_o !== 5'(mq.size())) begin
            errors++;
            $display("FAIL overrun_fill[%0d]: rts_n=%b level=%0d, required %b %0d",
                     i, rts_n_o, level_o, (mq.size() >= DEPTH - 2), mq.size());
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (irq_flags_o !== exp_irq() || irq_flags_o !== 6'b100111) begin
         errors++;
         $display("FAIL overrun_flags: irq=%b required %b", irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (rx_valid_o !== 1'b1 || rx_data_o !== mq[0]) begin
            errors++;
            $display("FAIL overrun_drain[%0d]: data=%h valid=%b, required %h 1",
                     i, rx_data_o, rx_valid_o, mq[0]);
         end
         @(posedge clk); #1;
         do_pop();
      end
      do_clear();
   endtask

   task automatic test_flush();
      div = 1;
      send_frame(8'h11, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      mq.delete();
      @(negedge clk);
      checks++;
      if (level_o !== 5'd0 || rx_valid_o !== 1'b0 || irq_flags_o !== exp_irq()) begin
         errors++;
         $display("FAIL flush: level=%0d valid=%b irq=%b, required 0 0 %b",
                  level_o, rx_valid_o, irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      div = 0;
   endtask

   task automatic test_break();
      div = 0;
      parity_i = PAR_NONE;
      two_stop_i = 1'b0;
      hold(1'b0, 3 * (DB + 2));
      @(negedge clk);
      mq.push_back('0);
      m_fe = 1'b1;
      checks++;
      if (level_o !== 5'd1 || rx_data_o !== '0 || irq_flags_o !== exp_irq()) begin
         errors++;
         $display("FAIL break_word: level=%0d data=%h irq=%b, required 1 00 %b",
                  level_o, rx_data_o, irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      hold(1'b1, 2);
      do_pop();
      do_clear();
      send_frame(8'h3C, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (level_o !== 5'd1 || rx_data_o !== 8'h3C || irq_flags_o !== exp_irq()) begin
         errors++;
         $display("FAIL break_recover: level=%0d data=%h irq=%b, required 1 3c %b",
                  level_o, rx_data_o, irq_flags_o, exp_irq());
      end
      @(posedge clk); #1;
      do_pop();
   endtask

   task automatic test_timeout();
      logic exp_to;
`ifdef UART_RX_TIMEOUT_EN
      exp_to = 1'b1;
`else
      exp_to = 1'b0;
`endif
      div = 0;
      send_frame(8'h81, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(1'b1, 26);
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: timeout=%b required 0", timeout_o);
      end
      @(posedge clk); #1;
      hold(1'b1, 15);
      @(negedge clk);
      checks++;
      if (timeout_o !== exp_to) begin
         errors++;
         $display("FAIL timeout_fire: timeout=%b required %b", timeout_o, exp_to);
      end
      @(posedge clk); #1;
      do_pop();
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b0 || level_o !== 5'd0) begin
         errors++;
         $display("FAIL timeout_pop: timeout=%b level=%0d, required 0 0", timeout_o, level_o);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_false_start();
      test_random();
      test_overrun();
      test_flush();
      test_break();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
